ddr3_read_arbiter: RTL and testbench
====================================

DDR3_READ_ARBITER -- requirements
Module: ddr3_read_arbiter

Interface
REQ-001 SHALL have parameter ADDRS, default 27: AXI byte-address width.
REQ-002 SHALL have parameter WIDTH, default 32: read-data width.
REQ-003 SHALL have parameter REQID, default 4: AXI ID width.
REQ-004 SHALL have port clock, input, 1: system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port s_arvalid_i, input, 2: per-requester AR valid; bit n = requester n.
REQ-007 SHALL have port s_arready_o, output, 2: per-requester AR ready.
REQ-008 SHALL have port s_araddr_i, input, 2*ADDRS: packed addresses; requester n in slice [n*ADDRS +: ADDRS].
REQ-009 SHALL have port s_arid_i, input, 2*REQID: packed IDs.
REQ-010 SHALL have port s_arlen_i, input, 16: packed burst lengths (8 b each).
REQ-011 SHALL have port s_arburst_i, input, 4: packed burst types (2 b each).
REQ-012 SHALL have port s_rvalid_o, output, 2: per-requester R valid.
REQ-013 SHALL have port s_rready_i, input, 2: per-requester R ready.
REQ-014 SHALL have port s_rlast_o, output, 1: shared R last, qualified by s_rvalid_o.
REQ-015 SHALL have port s_rresp_o, output, 2: shared R response.
REQ-016 SHALL have port s_rid_o, output, REQID: shared R ID.
REQ-017 SHALL have port s_rdata_o, output, WIDTH: shared R data.
REQ-018 SHALL have ports m_arvalid_o (out, 1), m_arready_i (in, 1), m_araddr_o (out, ADDRS), m_arid_o (out, REQID), m_arlen_o (out, 8), m_arburst_o (out, 2): downstream AR channel to the DDR3 controller.
REQ-019 SHALL have ports m_rvalid_i (in, 1), m_rready_o (out, 1), m_rlast_i (in, 1), m_rresp_i (in, 2), m_rid_i (in, REQID), m_rdata_i (in, WIDTH): downstream R channel.

Function
REQ-020 SHALL implement FSM states IDLE, ADDR, DATA; at most one burst outstanding downstream.
REQ-021 IDLE: if any s_arvalid_i bit set, SHALL grant one requester, register its addr/id/len/burst into m_ar* outputs, assert m_arvalid_o, and go to ADDR on the next edge.
REQ-022 Grant SHALL be round-robin: pointer prio (reset 0) gives preference to requester prio; on each grant prio <= ~granted index.
REQ-023 If only one requester is valid, it SHALL be granted regardless of prio.
REQ-024 s_arready_o[n] SHALL be 1 only in the IDLE cycle in which requester n is granted (registered capture, 1-cycle pulse).
REQ-025 ADDR: m_arvalid_o and m_ar* SHALL hold stable until m_arvalid_o & m_arready_i, then m_arvalid_o <= 0 and state <= DATA.
REQ-026 DATA: s_rvalid_o[g] = m_rvalid_i and m_rready_o = s_rready_i[g] (combinational, g = granted index); the other s_rvalid_o bit SHALL be 0.
REQ-027 s_rdata_o, s_rresp_o, s_rid_o, s_rlast_o SHALL pass m_r* through combinationally.
REQ-028 DATA: on m_rvalid_i & m_rready_o & m_rlast_i, SHALL return to IDLE; a new grant is possible on the following edge (min 1 idle cycle between bursts).
REQ-029 Outside DATA, m_rready_o and s_rvalid_o SHALL be 0; downstream R beats outside DATA are not forwarded.
REQ-030 A requester deasserting s_arvalid_i before grant SHALL not be granted; a requester is never granted twice while state != IDLE.
REQ-031 Burst length is passed unaltered; no beat counting — completion is solely by m_rlast_i.

Reset
REQ-032 On reset: state IDLE, prio 0, grant index 0, m_arvalid_o 0, s_arready_o 0, m_ar* registers 0.
REQ-033 Reset asserted in ADDR or DATA SHALL abandon the burst immediately; first post-reset grant follows REQ-021/022.

Verification
REQ-034 Requester 0 only, addr 0x10, len 3, id 2; m_arready_i=1 -> s_arready_o[0] pulse 1 cycle, m_araddr_o=0x10, m_arlen_o=3, 4 beats on s_rvalid_o[0], s_rvalid_o[1]=0 throughout.
REQ-035 Both valid from reset -> grant order 0,1,0,1 over four back-to-back requests per port.
REQ-036 m_arready_i held 0 for 5 cycles in ADDR -> m_arvalid_o and m_araddr_o stable all 5 cycles; handshake on cycle 6.
REQ-037 Granted requester drops s_rready_i mid-burst for 3 cycles -> m_rready_o=0 those cycles, no beat lost or duplicated, rlast delivered once.
REQ-038 Reset pulse during DATA beat 2 of 4 -> next cycle state IDLE, all outputs at reset values, next request granted normally.
REQ-039 Requester 1 valid, requester 0 valid one cycle later during requester 1 burst -> requester 0 granted only after requester 1 rlast plus one IDLE cycle.

Source files
------------

// File: rtl/ddr3_read_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_read_arbiter: two-port round-robin AXI read arbiter, one DDR3 burst in flight.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ddr3_read_arbiter #(
  parameter int ADDRS = 27,
  parameter int WIDTH = 32,
  parameter int REQID = 4
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic [1:0]           s_arvalid_i,
  output logic [1:0]           s_arready_o,
  input  logic [2*ADDRS-1:0]   s_araddr_i,
  input  logic [2*REQID-1:0]   s_arid_i,
  input  logic [15:0]          s_arlen_i,
  input  logic [3:0]           s_arburst_i,

  output logic [1:0]           s_rvalid_o,
  input  logic [1:0]           s_rready_i,
  output logic                 s_rlast_o,
  output logic [1:0]           s_rresp_o,
  output logic [REQID-1:0]     s_rid_o,
  output logic [WIDTH-1:0]     s_rdata_o,

  output logic                 m_arvalid_o,
  input  logic                 m_arready_i,
  output logic [ADDRS-1:0]     m_araddr_o,
  output logic [REQID-1:0]     m_arid_o,
  output logic [7:0]           m_arlen_o,
  output logic [1:0]           m_arburst_o,

  input  logic                 m_rvalid_i,
  output logic                 m_rready_o,
  input  logic                 m_rlast_i,
  input  logic [1:0]           m_rresp_i,
  input  logic [REQID-1:0]     m_rid_i,
  input  logic [WIDTH-1:0]     m_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               gnt_q, gnt_d;
  logic               arvalid_q, arvalid_d;
  logic [ADDRS-1:0]   araddr_q, araddr_d;
  logic [REQID-1:0]   arid_q, arid_d;
  logic [7:0]         arlen_q, arlen_d;
  logic [1:0]         arburst_q, arburst_d;

  // Contention resolves by the round-robin pointer; a lone requester always wins.
  logic               pick;
  logic [ADDRS-1:0]   pick_addr;
  logic [REQID-1:0]   pick_id;
  logic [7:0]         pick_len;
  logic [1:0]         pick_burst;
  logic               beat_fire;

  assign pick       = (&s_arvalid_i) ? prio_q : s_arvalid_i[1];
  assign pick_addr  = pick ? s_araddr_i[ADDRS +: ADDRS] : s_araddr_i[0 +: ADDRS];
  assign pick_id    = pick ? s_arid_i[REQID +: REQID]   : s_arid_i[0 +: REQID];
  assign pick_len   = pick ? s_arlen_i[15:8]            : s_arlen_i[7:0];
  assign pick_burst = pick ? s_arburst_i[3:2]           : s_arburst_i[1:0];
  assign beat_fire  = m_rvalid_i & s_rready_i[gnt_q];

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arid_d      = arid_q;
    arlen_d     = arlen_q;
    arburst_d   = arburst_q;
    s_arready_o = 2'b00;
    s_rvalid_o  = 2'b00;
    m_rready_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|s_arvalid_i) begin
          gnt_d     = pick;
          prio_d    = ~pick;
          arvalid_d = 1'b1;
          araddr_d  = pick_addr;
          arid_d    = pick_id;
          arlen_d   = pick_len;
          arburst_d = pick_burst;
          state_d   = ADDR;
          // Reset gating keeps the handshake from completing while the capture is discarded.
          if (!reset) begin
            s_arready_o = pick ? 2'b10 : 2'b01;
          end
        end
      end
      ADDR: begin
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!reset) begin
          m_rready_o = s_rready_i[gnt_q];
          s_rvalid_o = gnt_q ? {m_rvalid_i, 1'b0} : {1'b0, m_rvalid_i};
        end
        if (beat_fire && m_rlast_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      arlen_q   <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      arburst_q <= arburst_d;
    end
  end

  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = araddr_q;
  assign m_arid_o    = arid_q;
  assign m_arlen_o   = arlen_q;
  assign m_arburst_o = arburst_q;

  assign s_rdata_o   = m_rdata_i;
  assign s_rresp_o   = m_rresp_i;
  assign s_rid_o     = m_rid_i;
  assign s_rlast_o   = m_rlast_i;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_read_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ddr3_read_arbiter;

  localparam int ADDRS = 27;
  localparam int WIDTH = 32;
  localparam int REQID = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           s_arvalid_i;
  logic [1:0]           s_arready_o;
  logic [2*ADDRS-1:0]   s_araddr_i;
  logic [2*REQID-1:0]   s_arid_i;
  logic [15:0]          s_arlen_i;
  logic [3:0]           s_arburst_i;
  logic [1:0]           s_rvalid_o;
  logic [1:0]           s_rready_i;
  logic                 s_rlast_o;
  logic [1:0]           s_rresp_o;
  logic [REQID-1:0]     s_rid_o;
  logic [WIDTH-1:0]     s_rdata_o;
  logic                 m_arvalid_o;
  logic                 m_arready_i;
  logic [ADDRS-1:0]     m_araddr_o;
  logic [REQID-1:0]     m_arid_o;
  logic [7:0]           m_arlen_o;
  logic [1:0]           m_arburst_o;
  logic                 m_rvalid_i;
  logic                 m_rready_o;
  logic                 m_rlast_i;
  logic [1:0]           m_rresp_i;
  logic [REQID-1:0]     m_rid_i;
  logic [WIDTH-1:0]     m_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  ddr3_read_arbiter #(.ADDRS(ADDRS), .WIDTH(WIDTH), .REQID(REQID)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_arid_i(s_arid_i), .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rlast_o(s_rlast_o),
    .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rlast_i(m_rlast_i),
    .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    s_arvalid_i = '0; s_araddr_i = '0; s_arid_i = '0; s_arlen_i = '0; s_arburst_i = '0;
    s_rready_i = '0; m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
    m_rresp_i = '0; m_rid_i = '0; m_rdata_i = '0;
  endtask

  task automatic set_req(input int n, input logic [ADDRS-1:0] a, input logic [REQID-1:0] id,
                         input logic [7:0] len, input logic [1:0] bt);
    s_araddr_i[n*ADDRS +: ADDRS] = a;
    s_arid_i[n*REQID +: REQID]   = id;
    s_arlen_i[n*8 +: 8]          = len;
    s_arburst_i[n*2 +: 2]        = bt;
    s_arvalid_i[n]               = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    set_req(0, 27'h55, 4'h3, 8'd7, 2'd1);
    set_req(1, 27'h66, 4'h4, 8'd2, 2'd2);
    s_rready_i = 2'b11; m_rvalid_i = 1'b1; m_rlast_i = 1'b1;
    cyc(); cyc(); #1;
    n_checks++; if (s_arready_o !== 2'b00) $display("FAIL reset_arready got=%b exp=00", s_arready_o); else n_pass++;
    n_checks++; if (m_arvalid_o !== 1'b0) $display("FAIL reset_arvalid got=%b exp=0", m_arvalid_o); else n_pass++;
    n_checks++; if (m_araddr_o !== '0) $display("FAIL reset_araddr got=%h exp=0", m_araddr_o); else n_pass++;
    n_checks++; if ({m_arid_o, m_arlen_o, m_arburst_o} !== '0)
      $display("FAIL reset_arfields got=%h/%h/%h exp=0", m_arid_o, m_arlen_o, m_arburst_o); else n_pass++;
    n_checks++; if (m_rready_o !== 1'b0) $display("FAIL reset_rready got=%b exp=0", m_rready_o); else n_pass++;
    n_checks++; if (s_rvalid_o !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", s_rvalid_o); else n_pass++;
  endtask

  task automatic test_single_burst();
    do_reset();
    set_req(0, 27'h10, 4'h2, 8'd3, 2'd1);
    m_arready_i = 1'b1;
    #1;
    n_checks++; if (s_arready_o !== 2'b01) $display("FAIL single_grant got=%b exp=01", s_arready_o); else n_pass++;
    cyc();
    s_arvalid_i = 2'b00;
    #1;
    n_checks++; if (s_arready_o !== 2'b00) $display("FAIL single_pulse got=%b exp=00", s_arready_o); else n_pass++;
    n_checks++; if ({m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o} !== {1'b1, 27'h10, 4'h2, 8'd3, 2'd1})
      $display("FAIL single_ar got=%b/%h/%h/%h/%h exp=1/10/2/3/1", m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o);
    else n_pass++;
    cyc();
    m_arready_i = 1'b0;
    s_rready_i  = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 32'hA0 + b; m_rlast_i = (b == 3); m_rid_i = 4'h2;
      #1;
      n_checks++; if ({s_rvalid_o, m_rready_o, s_rlast_o, s_rdata_o, m_arvalid_o} !== {2'b01, 1'b1, (b == 3), 32'hA0 + b, 1'b0})
        $display("FAIL single_beat%0d got=%b/%b/%b/%h/%b", b, s_rvalid_o, m_rready_o, s_rlast_o, s_rdata_o, m_arvalid_o);
      else n_pass++;
      cyc();
    end
    m_rvalid_i = 1'b1; m_rlast_i = 1'b1;
    #1;
    n_checks++; if ({s_rvalid_o, m_rready_o} !== 3'b000)
      $display("FAIL single_idle_r got=%b/%b exp=00/0", s_rvalid_o, m_rready_o); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int cnt0, cnt1, w, exp_g;
    do_reset();
    cnt0 = 0; cnt1 = 0;
    m_arready_i = 1'b1; m_rvalid_i = 1'b1; m_rlast_i = 1'b1; s_rready_i = 2'b11;
    set_req(0, 27'h100, 4'h1, 8'd0, 2'd1);
    set_req(1, 27'h200, 4'h2, 8'd0, 2'd1);
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_g = k % 2;
      w = 0;
      while (s_arready_o == 2'b00 && w < 10) begin
        cyc();
        w++;
      end
      n_checks++; if (w >= 10) $display("FAIL rr_timeout k=%0d got=no grant exp=grant", k); else n_pass++;
      n_checks++; if (s_arready_o !== (exp_g ? 2'b10 : 2'b01))
        $display("FAIL rr_order k=%0d got=%b exp=%b", k, s_arready_o, (exp_g ? 2'b10 : 2'b01)); else n_pass++;
      cyc();
      if (exp_g == 0) cnt0++; else cnt1++;
      if (cnt0 == 4) s_arvalid_i[0] = 1'b0;
      if (cnt1 == 4) s_arvalid_i[1] = 1'b0;
      #1;
      n_checks++; if (m_araddr_o !== (exp_g ? 27'h200 : 27'h100))
        $display("FAIL rr_addr k=%0d got=%h exp=%h", k, m_araddr_o, (exp_g ? 27'h200 : 27'h100)); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_addr_stall();
    do_reset();
    set_req(1, 27'h1234, 4'h3, 8'd1, 2'd1);
    #1;
    n_checks++; if (s_arready_o !== 2'b10) $display("FAIL stall_grant got=%b exp=10", s_arready_o); else n_pass++;
    cyc();
    s_arvalid_i = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if ({m_arvalid_o, m_araddr_o} !== {1'b1, 27'h1234})
        $display("FAIL stall_hold c=%0d got=%b/%h exp=1/1234", c, m_arvalid_o, m_araddr_o); else n_pass++;
      cyc();
    end
    m_arready_i = 1'b1;
    #1;
    n_checks++; if (m_arvalid_o !== 1'b1) $display("FAIL stall_c6 got=%b exp=1", m_arvalid_o); else n_pass++;
    cyc();
    m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rlast_i = 1'b0; s_rready_i = 2'b10;
    #1;
    n_checks++; if ({m_arvalid_o, s_rvalid_o} !== 3'b010)
      $display("FAIL stall_post got=%b/%b exp=0/10", m_arvalid_o, s_rvalid_o); else n_pass++;
    cyc();
    m_rlast_i = 1'b1;
    #1;
    n_checks++; if ({s_rvalid_o, s_rlast_o} !== 3'b101)
      $display("FAIL stall_last got=%b/%b exp=10/1", s_rvalid_o, s_rlast_o); else n_pass++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] got[$];
    int beat, nlast;
    logic exp_rdy;
    do_reset();
    set_req(0, 27'h40, 4'h5, 8'd3, 2'd1);
    m_arready_i = 1'b1;
    cyc();
    s_arvalid_i = 2'b00;
    cyc();
    m_arready_i = 1'b0;
    beat = 0; nlast = 0;
    for (int c = 0; c < 12 && beat < 4; c++) begin
      exp_rdy = !(c >= 1 && c <= 3);
      s_rready_i = {1'b1, exp_rdy};
      m_rvalid_i = 1'b1; m_rdata_i = 32'hD0 + beat; m_rlast_i = (beat == 3); m_rid_i = 4'h5;
      #1;
      n_checks++; if (m_rready_o !== exp_rdy)
        $display("FAIL bp_rready c=%0d got=%b exp=%b", c, m_rready_o, exp_rdy); else n_pass++;
      if (s_rvalid_o[0] && s_rready_i[0]) begin
        got.push_back(s_rdata_o);
        if (s_rlast_o) nlast++;
      end
      if (exp_rdy) beat++;
      cyc();
    end
    clear_inputs();
    n_checks++; if (got.size() != 4) $display("FAIL bp_count got=%0d exp=4", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++; if (got[i] !== 32'hD0 + i) $display("FAIL bp_data%0d got=%h exp=%h", i, got[i], 32'hD0 + i); else n_pass++;
    end
    n_checks++; if (nlast != 1) $display("FAIL bp_rlast got=%0d exp=1", nlast); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 27'h80, 4'h6, 8'd3, 2'd1);
    m_arready_i = 1'b1;
    cyc();
    s_arvalid_i = 2'b00;
    cyc();
    m_arready_i = 1'b0; s_rready_i = 2'b11;
    for (int b = 0; b < 2; b++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 32'hE0 + b; m_rlast_i = 1'b0;
      #1;
      n_checks++; if (s_rvalid_o !== 2'b01) $display("FAIL rst_mid_beat%0d got=%b exp=01", b, s_rvalid_o); else n_pass++;
      cyc();
    end
    m_rdata_i = 32'hE2;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    n_checks++; if ({s_rvalid_o, m_rready_o, m_arvalid_o, s_arready_o} !== 6'b0)
      $display("FAIL rst_mid_ctl got=%b/%b/%b/%b exp=0", s_rvalid_o, m_rready_o, m_arvalid_o, s_arready_o); else n_pass++;
    n_checks++; if ({m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o} !== '0)
      $display("FAIL rst_mid_ar got=%h/%h/%h/%h exp=0", m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o); else n_pass++;
    m_rvalid_i = 1'b0;
    set_req(1, 27'h300, 4'h7, 8'd0, 2'd1);
    set_req(0, 27'h280, 4'h8, 8'd0, 2'd1);
    #1;
    n_checks++; if (s_arready_o !== 2'b01) $display("FAIL rst_mid_regrant got=%b exp=01", s_arready_o); else n_pass++;
    cyc();
    s_arvalid_i = 2'b00;
    #1;
    n_checks++; if ({m_arvalid_o, m_araddr_o} !== {1'b1, 27'h280})
      $display("FAIL rst_mid_ar2 got=%b/%h exp=1/280", m_arvalid_o, m_araddr_o); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_late_requester();
    do_reset();
    set_req(1, 27'h500, 4'h9, 8'd2, 2'd1);
    #1;
    n_checks++; if (s_arready_o !== 2'b10) $display("FAIL late_grant1 got=%b exp=10", s_arready_o); else n_pass++;
    cyc();
    s_arvalid_i = 2'b00;
    set_req(0, 27'h600, 4'hA, 8'd0, 2'd1);
    m_arready_i = 1'b1;
    #1;
    n_checks++; if (s_arready_o !== 2'b00) $display("FAIL late_addr got=%b exp=00", s_arready_o); else n_pass++;
    cyc();
    m_arready_i = 1'b0; s_rready_i = 2'b11;
    for (int b = 0; b < 3; b++) begin
      m_rvalid_i = 1'b1; m_rlast_i = (b == 2); m_rdata_i = 32'h70 + b;
      #1;
      n_checks++; if ({s_arready_o, s_rvalid_o} !== 4'b0010)
        $display("FAIL late_data%0d got=%b/%b exp=00/10", b, s_arready_o, s_rvalid_o); else n_pass++;
      cyc();
    end
    m_rvalid_i = 1'b0;
    #1;
    n_checks++; if (s_arready_o !== 2'b01) $display("FAIL late_grant0 got=%b exp=01", s_arready_o); else n_pass++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_random();
    bit               pend[2];
    logic [ADDRS-1:0] ra[2];
    logic [REQID-1:0] rid[2];
    logic [7:0]       rlen[2];
    logic [1:0]       rbt[2];
    bit               busy, ar_done, mprio;
    int               g, p, beats;
    logic [ADDRS-1:0] ea;
    logic [REQID-1:0] eid;
    logic [7:0]       elen;
    logic [1:0]       ebt;
    logic [1:0]       exp_ar, exp_rv;
    logic             exp_rr;
    do_reset();
    busy = 0; ar_done = 0; mprio = 0; g = 0; beats = 0;
    ea = '0; eid = '0; elen = '0; ebt = '0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 0; ra[n] = '0; rid[n] = '0; rlen[n] = '0; rbt[n] = '0;
    end
    for (int t = 0; t < 1500; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1;
          ra[n] = ADDRS'($urandom); rid[n] = REQID'($urandom);
          rlen[n] = 8'($urandom_range(0, 3)); rbt[n] = 2'($urandom);
        end else if (pend[n] && $urandom_range(0, 15) == 0) begin
          pend[n] = 0;
        end
        s_arvalid_i[n] = pend[n];
        s_araddr_i[n*ADDRS +: ADDRS] = ra[n];
        s_arid_i[n*REQID +: REQID]   = rid[n];
        s_arlen_i[n*8 +: 8]          = rlen[n];
        s_arburst_i[n*2 +: 2]        = rbt[n];
      end
      s_rready_i  = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      m_arready_i = 1'($urandom_range(0, 1));
      if (busy && ar_done) begin
        m_rvalid_i = ($urandom_range(0, 2) != 0);
        m_rlast_i  = (beats == int'(elen));
        m_rid_i    = eid;
      end else begin
        m_rvalid_i = ($urandom_range(0, 3) == 0);
        m_rlast_i  = 1'($urandom_range(0, 1));
        m_rid_i    = REQID'($urandom);
      end
      m_rdata_i = $urandom;
      m_rresp_i = 2'($urandom);
      #1;
      if (pend[0] && pend[1]) p = int'(mprio);
      else if (pend[0]) p = 0;
      else p = 1;
      exp_ar = (!busy && (pend[0] || pend[1])) ? (p == 1 ? 2'b10 : 2'b01) : 2'b00;
      exp_rv = (busy && ar_done && m_rvalid_i) ? (g == 1 ? 2'b10 : 2'b01) : 2'b00;
      exp_rr = busy && ar_done && s_rready_i[g];
      n_checks++; if (s_arready_o !== exp_ar) $display("FAIL rnd_arready t=%0d got=%b exp=%b", t, s_arready_o, exp_ar); else n_pass++;
      n_checks++; if (m_arvalid_o !== (busy && !ar_done))
        $display("FAIL rnd_arvalid t=%0d got=%b exp=%b", t, m_arvalid_o, (busy && !ar_done)); else n_pass++;
      if (busy && !ar_done) begin
        n_checks++; if ({m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o} !== {ea, eid, elen, ebt})
          $display("FAIL rnd_arfields t=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", t,
                   m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o, ea, eid, elen, ebt);
        else n_pass++;
      end
      n_checks++; if (s_rvalid_o !== exp_rv) $display("FAIL rnd_rvalid t=%0d got=%b exp=%b", t, s_rvalid_o, exp_rv); else n_pass++;
      n_checks++; if (m_rready_o !== exp_rr) $display("FAIL rnd_rready t=%0d got=%b exp=%b", t, m_rready_o, exp_rr); else n_pass++;
      n_checks++; if ({s_rdata_o, s_rresp_o, s_rid_o, s_rlast_o} !== {m_rdata_i, m_rresp_i, m_rid_i, m_rlast_i})
        $display("FAIL rnd_rpass t=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", t,
                 s_rdata_o, s_rresp_o, s_rid_o, s_rlast_o, m_rdata_i, m_rresp_i, m_rid_i, m_rlast_i);
      else n_pass++;
      if (!busy) begin
        if (pend[0] || pend[1]) begin
          busy = 1; ar_done = 0; g = p; mprio = (p == 0);
          ea = ra[p]; eid = rid[p]; elen = rlen[p]; ebt = rbt[p];
          pend[p] = 0;
        end
      end else if (!ar_done) begin
        if (m_arready_i) begin
          ar_done = 1; beats = 0;
        end
      end else if (m_rvalid_i && s_rready_i[g]) begin
        if (m_rlast_i) busy = 0;
        else beats++;
      end
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_addr_stall();
    test_backpressure();
    test_reset_mid_burst();
    test_late_requester();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
